// File: rtl/ssram_sp_param.sv
// Single-port synchronous SRAM with byte-masked writes, 1- or 2-cycle read latency
// and a one-word-per-cycle clear sweep that locks out accesses while it runs.
module ssram_sp_param #(
   parameter int unsigned DW         = 32,
   parameter int unsigned AW         = 9,
   parameter int unsigned RD_LAT     = 1,
   parameter bit          CLR_ON_RST = 1'b0
) (
   input  logic            CLK,
   input  logic            RSTN,
   input  logic            CEN,
   input  logic            GWEN,
   input  logic [DW/8-1:0] WEN,
   input  logic [AW-1:0]   A,
   input  logic [DW-1:0]   D,
   input  logic            CLR,
   output logic [DW-1:0]   Q,
   output logic            QV,
   output logic            BUSY
);

   localparam int unsigned NB       = DW / 8;
   localparam int unsigned DEPTH    = 2 ** AW;
   localparam logic [AW-1:0] CNT_LAST = {AW{1'b1}};

   typedef enum logic [0:0] {StIdle, StSweep} state_e;

   state_e        r_state;
   logic [AW-1:0] r_cnt;
   logic          r_busy;
   logic          r_init;
   logic [DW-1:0] r_mem [DEPTH];
   logic [DW-1:0] r_q;
   logic          r_qv;

   logic          w_acc;
   logic          w_rd;
   logic          w_wr;
   logic [DW-1:0] w_rdata;
   logic          w_fin_v;
   logic [DW-1:0] w_fin_d;

   assign w_acc   = !CEN && !r_busy;
   assign w_rd    = w_acc && GWEN;
   assign w_wr    = w_acc && !GWEN;
   assign w_rdata = r_mem[A];

   // Clear FSM; r_init arms the automatic sweep after reset release.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state <= StIdle;
         r_cnt   <= '0;
         r_busy  <= 1'b0;
         r_init  <= CLR_ON_RST;
      end else begin
         case (r_state)
            StIdle: begin
               if (CLR || r_init) begin
                  r_state <= StSweep;
                  r_busy  <= 1'b1;
                  r_cnt   <= '0;
                  r_init  <= 1'b0;
               end
            end
            StSweep: begin
               if (r_cnt == CNT_LAST) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + AW'(1);
               end
            end
            default: begin
               r_state <= StIdle;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Array is deliberately not reset; r_busy drops on reset so a sweep stops at once.
   always_ff @(posedge CLK) begin
      if (r_busy) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr) begin
         for (int i = 0; i < NB; i++) begin
            if (!WEN[i]) begin
               r_mem[A][8*i +: 8] <= D[8*i +: 8];
            end
         end
      end
   end

   if (RD_LAT == 2) begin : g_lat2
      logic          r_p_v;
      logic [DW-1:0] r_p_d;

      always_ff @(posedge CLK or negedge RSTN) begin
         if (!RSTN) begin
            r_p_v <= 1'b0;
            r_p_d <= '0;
         end else begin
            r_p_v <= w_rd;
            if (w_rd) begin
               r_p_d <= w_rdata;
            end
         end
      end

      assign w_fin_v = r_p_v;
      assign w_fin_d = r_p_d;
   end else begin : g_lat1
      assign w_fin_v = w_rd;
      assign w_fin_d = w_rdata;
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_q  <= '0;
         r_qv <= 1'b0;
      end else begin
         r_qv <= w_fin_v;
         if (w_fin_v) begin
            r_q <= w_fin_d;
         end
      end
   end

   assign Q    = r_q;
   assign QV   = r_qv;
   assign BUSY = r_busy;

endmodule

// File: tb/tb_ssram_sp_param.sv
// Randomised scoreboard bench: two DUTs (read latency 1 and 2) share stimulus and a
// behavioural memory model; a third instance checks the automatic clear after reset.
module tb_ssram_sp_param;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned NB    = DW / 8;
   localparam int unsigned DEPTH = 2 ** AW;

   typedef struct packed {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic          CLK = 1'b0;
   logic          RSTN;
   logic          cen, gwen, clr;
   logic [NB-1:0] wen;
   logic [AW-1:0] a;
   logic [DW-1:0] d;

   logic [DW-1:0] q1, q2;
   logic          qv1, qv2, busy1, busy2;
   logic [15:0]   q3;
   logic          qv3, busy3;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   exp_t          sb1[$];
   exp_t          sb2[$];
   exp_t          e1, e2;
   logic [DW-1:0] last1 = '0;
   logic [DW-1:0] last2 = '0;

   logic [DW-1:0] m_mem [DEPTH];
   logic          m_busy = 1'b0;
   int            m_cnt  = 0;

   ssram_sp_param #(.DW(DW), .AW(AW), .RD_LAT(1), .CLR_ON_RST(1'b0)) u_l1 (
      .CLK(CLK), .RSTN(RSTN), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d),
      .CLR(clr), .Q(q1), .QV(qv1), .BUSY(busy1)
   );

   ssram_sp_param #(.DW(DW), .AW(AW), .RD_LAT(2), .CLR_ON_RST(1'b0)) u_l2 (
      .CLK(CLK), .RSTN(RSTN), .CEN(cen), .GWEN(gwen), .WEN(wen), .A(a), .D(d),
      .CLR(clr), .Q(q2), .QV(qv2), .BUSY(busy2)
   );

   ssram_sp_param #(.DW(16), .AW(3), .RD_LAT(1), .CLR_ON_RST(1'b1)) u_cr (
      .CLK(CLK), .RSTN(RSTN), .CEN(1'b1), .GWEN(1'b1), .WEN(2'b11), .A(3'd0),
      .D(16'h0000), .CLR(1'b0), .Q(q3), .QV(qv3), .BUSY(busy3)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge CLK) begin
      if (qv1) begin
         if (sb1.size() == 0) begin
            chk("l1_qv_unexpected", qv1, 1'b0);
         end else begin
            e1 = sb1.pop_front();
            chk("l1_qv_cycle", cyc, e1.cyc);
            chk("l1_q", q1, e1.data);
            last1 = e1.data;
         end
      end else begin
         chk("l1_q_hold", q1, last1);
         if (sb1.size() > 0 && sb1[0].cyc <= cyc) begin
            e1 = sb1.pop_front();
            chk("l1_qv_missing", qv1, 1'b1);
         end
      end
   end

   always @(negedge CLK) begin
      if (qv2) begin
         if (sb2.size() == 0) begin
            chk("l2_qv_unexpected", qv2, 1'b0);
         end else begin
            e2 = sb2.pop_front();
            chk("l2_qv_cycle", cyc, e2.cyc);
            chk("l2_q", q2, e2.data);
            last2 = e2.data;
         end
      end else begin
         chk("l2_q_hold", q2, last2);
         if (sb2.size() > 0 && sb2[0].cyc <= cyc) begin
            e2 = sb2.pop_front();
            chk("l2_qv_missing", qv2, 1'b1);
         end
      end
   end

   // Drive one cycle of stimulus just after a falling edge, predict the next rising edge,
   // then check BUSY on the following falling edge.
   task automatic step(input logic i_cen, input logic i_gwen, input logic [NB-1:0] i_wen,
                       input logic [AW-1:0] i_a, input logic [DW-1:0] i_d, input logic i_clr);
      int e;
      exp_t x;
      cen  = i_cen;
      gwen = i_gwen;
      wen  = i_wen;
      a    = i_a;
      d    = i_d;
      clr  = i_clr;
      e    = cyc + 1;
      if (!i_cen && !m_busy) begin
         if (i_gwen) begin
            x.data = m_mem[i_a];
            x.cyc  = e;
            sb1.push_back(x);
            x.cyc  = e + 1;
            sb2.push_back(x);
         end else begin
            for (int i = 0; i < NB; i++) begin
               if (!i_wen[i]) m_mem[i_a][8*i +: 8] = i_d[8*i +: 8];
            end
         end
      end
      if (m_busy) begin
         m_mem[m_cnt] = '0;
         if (m_cnt == DEPTH - 1) begin
            m_busy = 1'b0;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
      end else if (i_clr) begin
         m_busy = 1'b1;
         m_cnt  = 0;
      end
      @(posedge CLK);
      @(negedge CLK);
      chk("l1_busy", busy1, m_busy);
      chk("l2_busy", busy2, m_busy);
   endtask

   task automatic idle();
      step(1'b1, 1'b1, '1, '0, '0, 1'b0);
   endtask

   task automatic rd(input logic [AW-1:0] i_a, input logic i_clr);
      step(1'b0, 1'b1, '1, i_a, '0, i_clr);
   endtask

   task automatic wr(input logic [AW-1:0] i_a, input logic [DW-1:0] i_d, input logic [NB-1:0] i_wen);
      step(1'b0, 1'b0, i_wen, i_a, i_d, 1'b0);
   endtask

   task automatic do_reset();
      #2 RSTN = 1'b0;
      #1;
      chk("rst_l1_q", q1, '0);
      chk("rst_l1_qv", qv1, 1'b0);
      chk("rst_l1_busy", busy1, 1'b0);
      chk("rst_l2_q", q2, '0);
      chk("rst_l2_qv", qv2, 1'b0);
      chk("rst_l2_busy", busy2, 1'b0);
      chk("rst_pending_reads", sb1.size() + sb2.size(), 0);
      m_busy = 1'b0;
      m_cnt  = 0;
      last1  = '0;
      last2  = '0;
      repeat (2) @(negedge CLK);
      #2 RSTN = 1'b1;
      @(negedge CLK);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      RSTN = 1'b1;
      cen  = 1'b1;
      gwen = 1'b1;
      wen  = '1;
      a    = '0;
      d    = '0;
      clr  = 1'b0;
      #1 RSTN = 1'b0;
      #1;
      chk("init_l1_q", q1, '0);
      chk("init_l1_qv", qv1, 1'b0);
      chk("init_l1_busy", busy1, 1'b0);
      chk("init_l2_qv", qv2, 1'b0);
      chk("init_cr_busy", busy3, 1'b0);
      @(negedge CLK);
      @(negedge CLK);
      #2 RSTN = 1'b1;

      // Auto-clear instance: 8 words, busy from the first edge after release.
      for (int k = 1; k <= 10; k++) begin
         @(negedge CLK);
         chk("cr_busy", busy3, (k <= 8));
         chk("cr_qv", qv3, 1'b0);
      end
      chk("cr_q", q3, '0);

      // Full clear; an access during the sweep must be dropped.
      step(1'b1, 1'b1, '1, '0, '0, 1'b1);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 3)      wr(4'd2, 32'hFFFF_FFFF, 4'b0000);
         else if (i == 5) rd(4'd4, 1'b0);
         else if (i == 7) step(1'b1, 1'b1, '1, '0, '0, 1'b1);
         else             idle();
      end
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), 1'b0);

      wr(4'd5, 32'hDEAD_BEEF, 4'b0000);
      rd(4'd5, 1'b0);
      wr(4'd7, 32'h1122_3344, 4'b0000);
      wr(4'd7, 32'hAABB_CCDD, 4'b1010);
      rd(4'd7, 1'b0);
      chk("mask_model", m_mem[7], 32'h11BB_33DD);
      wr(4'd1, 32'h0000_0101, 4'b0000);
      wr(4'd2, 32'h0000_0202, 4'b0000);
      wr(4'd3, 32'h0000_0055, 4'b0000);
      rd(4'd1, 1'b0);
      rd(4'd2, 1'b0);
      rd(4'd3, 1'b0);
      idle();
      rd(4'd2, 1'b0);
      rd(4'd3, 1'b1);
      for (int i = 0; i < DEPTH + 2; i++) idle();
      rd(4'd3, 1'b0);

      for (int n = 0; n < 400; n++) begin
         step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), NB'($urandom),
              AW'($urandom), $urandom, ($urandom_range(0, 49) == 0));
      end
      for (int i = 0; i < DEPTH + 2; i++) idle();

      // Reset eight words into a sweep: the upper half must survive.
      for (int i = 0; i < DEPTH; i++) wr(AW'(i), $urandom | 32'h1, 4'b0000);
      repeat (2) idle();
      step(1'b1, 1'b1, '1, '0, '0, 1'b1);
      repeat (8) idle();
      do_reset();
      for (int i = 0; i < DEPTH; i++) rd(AW'(i), 1'b0);

      repeat (4) idle();
      chk("drain_l1", sb1.size(), 0);
      chk("drain_l2", sb2.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ssram_sp_param.md
SSRAM_SP_PARAM -- requirements
Module: ssram_sp_param

Interface
REQ-001 Parameter DW, default 32: data width in bits; SHALL be a multiple of 8, minimum 8.
REQ-002 Parameter AW, default 9: address width; depth SHALL be 2**AW words.
REQ-003 Parameter RD_LAT, default 1: read latency in cycles; legal values 1 or 2.
REQ-004 Parameter CLR_ON_RST, default 0: when 1, a clear sweep starts automatically after reset release.
REQ-005 Port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-006 Port RSTN, input, 1: reset, asynchronous, active-low.
REQ-007 Port CEN, input, 1: chip enable, active-low; 0 = access this cycle.
REQ-008 Port GWEN, input, 1: global write enable, active-low; 0 = write, 1 = read.
REQ-009 Port WEN, input, DW/8: per-byte write enable, active-low; only used when GWEN=0.
REQ-010 Port A, input, AW: word address.
REQ-011 Port D, input, DW: write data.
REQ-012 Port CLR, input, 1: one-cycle request to zero the whole array.
REQ-013 Port Q, output, DW: read data.
REQ-014 Port QV, output, 1: read-data-valid strobe, one cycle per completed read.
REQ-015 Port BUSY, output, 1: high while a clear sweep is in progress; accesses are refused.

Function
REQ-016 Read (CEN=0, GWEN=1, BUSY=0) SHALL present mem[A] on Q, with QV=1, exactly RD_LAT cycles after the sampling edge.
REQ-017 With RD_LAT=2, back-to-back reads SHALL pipeline at one read per cycle, with Q/QV returned in issue order.
REQ-018 Write (CEN=0, GWEN=0, BUSY=0) SHALL update each byte i of mem[A] from D[8i+7:8i] only where WEN[i]=0; other bytes are unchanged.
REQ-019 A write SHALL NOT change Q and SHALL NOT assert QV; Q holds its last read value.
REQ-020 A read issued the cycle after a write to the same address SHALL return the newly written data.
REQ-021 CEN=1 SHALL leave memory and Q unchanged; QV SHALL still deassert in step with the read pipeline.
REQ-022 Q SHALL hold its value between reads; QV SHALL be 0 in every cycle without a completed read.
REQ-023 Clear FSM states: IDLE, SWEEP. IDLE->SWEEP on CLR=1 sampled high; in SWEEP one word per cycle is written to 0, counter 0..2**AW-1; SWEEP->IDLE after the last word is written.
REQ-024 BUSY SHALL be 1 exactly during SWEEP: 2**AW cycles, starting the cycle after CLR is sampled.
REQ-025 Access requests while BUSY=1 SHALL be ignored: no memory write, no QV.
REQ-026 CLR asserted while BUSY=1 SHALL be ignored; the sweep does not restart.
REQ-027 CLR and an access in the same cycle from IDLE: the access SHALL complete first (a read returns pre-clear data), then the sweep begins.
REQ-028 Reads in flight when SWEEP starts (RD_LAT=2) SHALL still complete with QV=1 and pre-clear data.
REQ-029 The sweep counter SHALL NOT wrap: the final word is 2**AW-1, then the FSM returns to IDLE.

Reset
REQ-030 RSTN=0 SHALL immediately force Q=0, QV=0, BUSY=0, FSM=IDLE, sweep counter=0, and read pipeline empty.
REQ-031 Memory contents SHALL NOT be affected by reset; contents after power-up are undefined unless cleared.
REQ-032 With CLR_ON_RST=1, the FSM SHALL enter SWEEP on the first rising edge after RSTN deasserts.
REQ-033 Reset asserted mid-sweep SHALL abort the sweep; words not yet cleared keep their prior contents.

Verification
REQ-034 DW=32, RD_LAT=1: write 0xDEADBEEF to A=5 with WEN=0000, then read A=5 -> next cycle Q=0xDEADBEEF, QV=1 for 1 cycle.
REQ-035 Byte mask: mem[7]=0x11223344; write D=0xAABBCCDD, WEN=1010 -> read A=7 returns 0x11BB33DD.
REQ-036 RD_LAT=2: reads A=1,2,3 on consecutive cycles -> Q = mem[1], mem[2], mem[3] on cycles 2,3,4 after the first issue, QV high for 3 cycles.
REQ-037 AW=4: pulse CLR -> BUSY high for exactly 16 cycles; a write issued during BUSY is dropped; afterwards all 16 words read 0.
REQ-038 Assert RSTN=0 at sweep count 8 with AW=4 -> BUSY=0 and Q=0 immediately; words 0-7 read 0, words 8-15 keep their prior contents.
REQ-039 CLR together with a read of A=3 (mem[3]=0x55) -> Q=0x55, QV=1; BUSY rises the next cycle.
